// File: rtl/register_file_pkg.sv
// register_file_pkg: shared defaults, popcount helper and write-port struct for register_file_mp
package register_file_pkg;
  localparam int NLOC_DEF = 32;
  localparam int DBITS_DEF = 32;
  localparam int AW_DEF = $clog2(NLOC_DEF);
  localparam int NLOC_MAX = 256;
  typedef struct packed {
    logic en;
    logic [AW_DEF-1:0] addr;
    logic [DBITS_DEF-1:0] data;
  } wr_port_t;
  function automatic int unsigned popcount(input logic [NLOC_MAX-1:0] v);
    popcount = 0;
    for (int i = 0; i < NLOC_MAX; i++) popcount = popcount + 32'(v[i]);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits (write clears, reserve sets and wins), registered busy count; ports clk/rst, write enables/addrs, reserve, busy vector, count
import register_file_pkg::*;
module rf_scoreboard #(
  parameter int Nloc = NLOC_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(Nloc),
  localparam int CW = $clog2(Nloc + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_wr,
  input  logic [2*AW-1:0] i_waddr,
  input  logic            i_rsv,
  input  logic [AW-1:0]   i_rsv_addr,
  output logic [Nloc-1:0] o_busy,
  output logic [CW-1:0]   o_count
);
  logic [Nloc-1:0] r_busy, w_next;
  logic [CW-1:0] r_count;
  always_comb begin
    w_next = r_busy;
    for (int i = 0; i < 2; i++) if (i_wr[i]) w_next[i_waddr[i*AW +: AW]] = 1'b0;
    if (i_rsv) w_next[i_rsv_addr] = 1'b1;
    if (ZERO_REG != 0) w_next[0] = 1'b0;
  end
  // count is taken from the next vector so it lines up with the bits it describes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy <= '0;
      r_count <= '0;
    end else begin
      r_busy <= w_next;
      r_count <= CW'(popcount(NLOC_MAX'(w_next)));
    end
  assign o_busy = r_busy;
  assign o_count = r_count;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: 2-write/NREAD-read register file with busy scoreboard; ports clock, reset, wr/WriteAddr/WriteData, ReadAddr/ReadData/ReadBusy, rsv/RsvAddr, busy_count; REGFILE_BYPASS_EN enables write-to-read bypass
import register_file_pkg::*;
module register_file_mp #(
  parameter int Nloc = NLOC_DEF,
  parameter int Dbits = DBITS_DEF,
  parameter int NREAD = 3,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(Nloc),
  localparam int CW = $clog2(Nloc + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         wr,
  input  logic [2*AW-1:0]    WriteAddr,
  input  logic [2*Dbits-1:0] WriteData,
  input  logic [NREAD*AW-1:0]    ReadAddr,
  output logic [NREAD*Dbits-1:0] ReadData,
  output logic [NREAD-1:0]   ReadBusy,
  input  logic               rsv,
  input  logic [AW-1:0]      RsvAddr,
  output logic [CW-1:0]      busy_count
);
  logic [Dbits-1:0] r_rf [Nloc];
  logic [Nloc-1:0] w_busy;
  rf_scoreboard #(.Nloc(Nloc), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clock), .rst(reset), .i_wr(wr), .i_waddr(WriteAddr),
    .i_rsv(rsv), .i_rsv_addr(RsvAddr), .o_busy(w_busy), .o_count(busy_count)
  );
  // port 1 is assigned last, so it wins on an address collision
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int j = 0; j < Nloc; j++) r_rf[j] <= '0;
    else for (int i = 0; i < 2; i++)
      if (wr[i] && !(ZERO_REG != 0 && WriteAddr[i*AW +: AW] == '0))
        r_rf[WriteAddr[i*AW +: AW]] <= WriteData[i*Dbits +: Dbits];
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic [Dbits-1:0] w_d;
    logic w_b;
    assign w_a = ReadAddr[k*AW +: AW];
    always_comb begin
      w_d = r_rf[w_a];
      w_b = w_busy[w_a];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < 2; i++)
        if (!reset && wr[i] && WriteAddr[i*AW +: AW] == w_a) begin
          w_d = WriteData[i*Dbits +: Dbits];
          w_b = rsv && RsvAddr == w_a;
        end
`else
`endif
      if (ZERO_REG != 0 && w_a == '0) begin
        w_d = '0;
        w_b = 1'b0;
      end
    end
    assign ReadData[k*Dbits +: Dbits] = w_d;
    assign ReadBusy[k] = w_b;
  end
endmodule
